food_ctrl: RTL and testbench

FOOD_CTRL -- requirements
Module: food_ctrl

---
 rtl/food_if.sv | 22 ++
 rtl/food_ctrl.sv | 74 +++++++
 tb/tb_food_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/food_if.sv
// food_if: food controller handshake bundle (request, tracker query, placement status)
interface food_if;
  logic       eaten;
  logic [7:0] rnd_pos;
  logic       occ_req;
  logic [7:0] occ_pos;
  logic       occ_ack;
  logic       occ_hit;
  logic [7:0] food_pos;
  logic       food_valid;
  logic       done;
  logic       board_full;
  logic       busy;
  modport master (
    output eaten, rnd_pos, occ_ack, occ_hit,
    input  occ_req, occ_pos, food_pos, food_valid, done, board_full, busy
  );
  modport slave (
    input  eaten, rnd_pos, occ_ack, occ_hit,
    output occ_req, occ_pos, food_pos, food_valid, done, board_full, busy
  );
endinterface

// File: rtl/food_ctrl.sv
// food_ctrl: places food on a free cell, random candidates first, then a linear scan
module food_ctrl #(
  parameter int MAX_TRIES = 8
) (
  input logic clk,
  input logic rst,
  food_if.slave f
);
  localparam logic [2:0] INIT = 3'd0, SAMPLE = 3'd1, QUERY = 3'd2, COMMIT = 3'd3, IDLE = 3'd4;
  logic [2:0] state;
  logic [7:0] cand;
  logic [7:0] next_cand;
  logic [3:0] try_cnt;
  logic [8:0] scan_cnt;
  logic       scan;
  assign next_cand = scan ? cand + 8'd1 : f.rnd_pos;
  assign f.busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      cand         <= 8'h00;
      try_cnt      <= 4'd0;
      scan_cnt     <= 9'd0;
      scan         <= 1'b0;
      f.occ_req    <= 1'b0;
      f.occ_pos    <= 8'h00;
      f.food_pos   <= 8'h00;
      f.food_valid <= 1'b0;
      f.done       <= 1'b0;
      f.board_full <= 1'b0;
    end else begin
      f.done <= 1'b0;
      case (state)
        INIT: state <= SAMPLE;
        SAMPLE: begin
          cand      <= next_cand;
          f.occ_pos <= next_cand;
          f.occ_req <= 1'b1;
          if (scan) scan_cnt <= scan_cnt + 9'd1;
          else try_cnt <= try_cnt + 4'd1;
          state <= QUERY;
        end
        QUERY: if (f.occ_ack) begin
          f.occ_req <= 1'b0;
          if (!f.occ_hit) state <= COMMIT;
          else if (scan && scan_cnt == 9'd256) begin
            // every cell was probed and all were taken: keep the old food_pos
            state        <= IDLE;
            f.board_full <= 1'b1;
            f.food_valid <= 1'b0;
          end else begin
            if (!scan && int'(try_cnt) >= MAX_TRIES) scan <= 1'b1;
            state <= SAMPLE;
          end
        end
        COMMIT: begin
          f.food_pos   <= cand;
          f.food_valid <= 1'b1;
          f.done       <= 1'b1;
          state        <= IDLE;
        end
        IDLE: if (f.eaten) begin
          f.food_valid <= 1'b0;
          f.board_full <= 1'b0;
          try_cnt      <= 4'd0;
          scan_cnt     <= 9'd0;
          scan         <= 1'b0;
          state        <= SAMPLE;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_food_ctrl.sv
// tb_food_ctrl: directed vectors for food_ctrl with a scripted occupancy tracker
module tb_food_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rnd_run = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   nq;
  logic [7:0] qpos [300];
  food_if f ();
  food_ctrl #(.MAX_TRIES(8)) dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (rnd_run) f.rnd_pos = f.rnd_pos + 8'd1;
  endtask
  task automatic pulse_eaten();
    f.eaten = 1'b1;
    tick();
    f.eaten = 1'b0;
  endtask
  // answers queries until done or board_full; hit while fewer than nhit answered, unless occ_pos == free
  task automatic serve(input int delay, input int nhit, input logic [8:0] free, output int n);
    int w;
    n = 0;
    forever begin
      w = 0;
      while (!f.occ_req && !f.done && !(f.board_full && !f.busy) && w < 40) begin
        tick();
        w++;
      end
      if (w >= 40) begin
        check("query_wait", 32'(w), 32'd0);
        return;
      end
      if (f.done || (f.board_full && !f.busy)) return;
      if (n < 300) qpos[n] = f.occ_pos;
      for (int d = 0; d < delay; d++) begin
        tick();
        check("req_held", 32'(f.occ_req), 32'd1);
        check("pos_held", 32'(f.occ_pos), 32'(qpos[n]));
      end
      f.occ_ack = 1'b1;
      f.occ_hit = (n < nhit) && ({1'b0, f.occ_pos} != free);
      n++;
      tick();
      f.occ_ack = 1'b0;
      f.occ_hit = 1'b0;
      check("req_drop", 32'(f.occ_req), 32'd0);
    end
  endtask
  initial begin
    f.eaten = 1'b0;
    f.rnd_pos = 8'h35;
    f.occ_ack = 1'b0;
    f.occ_hit = 1'b0;
    repeat (3) tick();
    check("rst_food_pos", 32'(f.food_pos), 32'h00);
    check("rst_valid", 32'(f.food_valid), 32'd0);
    check("rst_done", 32'(f.done), 32'd0);
    check("rst_full", 32'(f.board_full), 32'd0);
    check("rst_req", 32'(f.occ_req), 32'd0);
    check("rst_pos", 32'(f.occ_pos), 32'h00);
    check("rst_busy", 32'(f.busy), 32'd1);
    rst = 1'b0;
    tick();
    check("init_busy", 32'(f.busy), 32'd1);
    tick();
    check("q1_req", 32'(f.occ_req), 32'd1);
    check("q1_pos", 32'(f.occ_pos), 32'h35);
    f.occ_ack = 1'b1;
    tick();
    f.occ_ack = 1'b0;
    check("q1_drop", 32'(f.occ_req), 32'd0);
    check("q1_nodone", 32'(f.done), 32'd0);
    tick();
    check("q1_done", 32'(f.done), 32'd1);
    check("q1_food", 32'(f.food_pos), 32'h35);
    check("q1_valid", 32'(f.food_valid), 32'd1);
    check("q1_idle", 32'(f.busy), 32'd0);
    tick();
    check("q1_done_once", 32'(f.done), 32'd0);
    f.rnd_pos = 8'h5A;
    pulse_eaten();
    check("e2_valid_clr", 32'(f.food_valid), 32'd0);
    check("e2_busy", 32'(f.busy), 32'd1);
    serve(5, 0, 9'h100, nq);
    check("e2_nq", 32'(nq), 32'd1);
    check("e2_done", 32'(f.done), 32'd1);
    check("e2_food", 32'(f.food_pos), 32'h5A);
    tick();
    check("e2_done_once", 32'(f.done), 32'd0);
    rnd_run = 1'b1;
    pulse_eaten();
    serve(0, 3, 9'h100, nq);
    check("e3_nq", 32'(nq), 32'd4);
    check("e3_step", 32'(qpos[1]), 32'(8'(qpos[0] + 8'd2)));
    check("e3_last", 32'(qpos[3]), 32'(8'(qpos[0] + 8'd6)));
    check("e3_food", 32'(f.food_pos), 32'(qpos[3]));
    check("e3_valid", 32'(f.food_valid), 32'd1);
    rnd_run = 1'b0;
    f.rnd_pos = 8'hFE;
    tick();
    pulse_eaten();
    serve(0, 1000, 9'h001, nq);
    check("e4_nq", 32'(nq), 32'd11);
    check("e4_rand", 32'(qpos[7]), 32'hFE);
    check("e4_scan0", 32'(qpos[8]), 32'hFF);
    check("e4_scan1", 32'(qpos[9]), 32'h00);
    check("e4_scan2", 32'(qpos[10]), 32'h01);
    check("e4_food", 32'(f.food_pos), 32'h01);
    check("e4_done", 32'(f.done), 32'd1);
    tick();
    pulse_eaten();
    serve(0, 1000, 9'h100, nq);
    check("e5_nq", 32'(nq), 32'd264);
    check("e5_full", 32'(f.board_full), 32'd1);
    check("e5_valid", 32'(f.food_valid), 32'd0);
    check("e5_busy", 32'(f.busy), 32'd0);
    check("e5_done", 32'(f.done), 32'd0);
    check("e5_food_kept", 32'(f.food_pos), 32'h01);
    tick();
    check("e5_nodone", 32'(f.done), 32'd0);
    f.rnd_pos = 8'h77;
    pulse_eaten();
    check("e6_full_clr", 32'(f.board_full), 32'd0);
    check("e6_busy", 32'(f.busy), 32'd1);
    tick();
    check("e6_req", 32'(f.occ_req), 32'd1);
    rst = 1'b1;
    f.occ_ack = 1'b1;
    tick();
    rst = 1'b0;
    f.occ_ack = 1'b0;
    check("e6_rst_req", 32'(f.occ_req), 32'd0);
    check("e6_rst_busy", 32'(f.busy), 32'd1);
    check("e6_rst_done", 32'(f.done), 32'd0);
    check("e6_rst_food", 32'(f.food_pos), 32'h00);
    pulse_eaten();
    serve(0, 0, 9'h100, nq);
    check("e6_nq", 32'(nq), 32'd1);
    check("e6_done", 32'(f.done), 32'd1);
    check("e6_food", 32'(f.food_pos), 32'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("e6_no_extra", 32'({f.busy, f.occ_req, f.done}), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
